ex_muldiv_unit: RTL and testbench

//  Parametrised RV32M/RV64M multiply/divide unit attached beside the EX-stage ALU.

---
 rtl/ex_muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multiply/divide unit beside the EX-stage ALU: fixed-latency multiply,
// iterative restoring divide, stall request while busy, and kill/pipeline-reset abort.
module ex_muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_LAT    = 2,
    parameter int unsigned DIV_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_adr_in,
    input  logic            kill,
    input  logic            rst_pipe,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_adr_out
);

    localparam int unsigned DivCycles = XLEN / DIV_UNROLL;
    localparam int unsigned CntW      = 7;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, res_q, res_d;
    logic [4:0]      rd_q, rd_out_q, rd_out_d;

    logic            in_idle, flush, accept;
    logic [2:0]      op;
    logic [XLEN-1:0] opa, opb;

    assign in_idle = (state_q == StIdle);
    assign flush   = kill | rst_pipe;
    assign accept  = start & in_idle & ~flush;

    // Operands come straight from the inputs in the accept cycle, from the latches afterwards.
    assign op  = in_idle ? funct3 : op_q;
    assign opa = in_idle ? rs1 : a_q;
    assign opb = in_idle ? rs2 : b_q;

    // Multiply: sign-extend to 2*XLEN so one modular product serves all four variants.
    logic                a_sx, b_sx;
    logic [2*XLEN-1:0]   mul_a, mul_b, prod;
    logic [XLEN-1:0]     mul_res;

    assign a_sx    = (op[1:0] != 2'b11) & opa[XLEN-1];
    assign b_sx    = ~op[1] & opb[XLEN-1];
    assign mul_a   = {{XLEN{a_sx}}, opa};
    assign mul_b   = {{XLEN{b_sx}}, opb};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs, special_res, q_fix, r_fix, fix_res;

    assign div_signed  = ~op[0];
    assign a_neg       = div_signed & opa[XLEN-1];
    assign b_neg       = div_signed & opb[XLEN-1];
    assign a_abs       = a_neg ? -opa : opa;
    assign b_abs       = b_neg ? -opb : opb;
    assign div_zero    = (opb == '0);
    assign div_ovf     = div_signed & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (&opb);
    assign special_res = div_zero ? (op[1] ? opa : '1) : (op[1] ? '0 : opa);
    assign q_fix       = (a_neg ^ b_neg) ? -quo_q : quo_q;
    assign r_fix       = a_neg ? -rem_q : rem_q;
    assign fix_res     = op[1] ? r_fix : q_fix;

    // The accept cycle performs the first restoring step so DIV+FIX fit in XLEN/DIV_UNROLL cycles.
    logic [XLEN-1:0] rem_w, quo_w;
    logic [XLEN:0]   sh;

    always_comb begin
        rem_w = in_idle ? '0 : rem_q;
        quo_w = in_idle ? a_abs : quo_q;
        sh    = '0;
        for (int unsigned i = 0; i < DIV_UNROLL; i++) begin
            sh    = {rem_w, quo_w[XLEN-1]};
            quo_w = {quo_w[XLEN-2:0], 1'b0};
            if (sh >= {1'b0, b_abs}) begin
                rem_w    = XLEN'(sh - {1'b0, b_abs});
                quo_w[0] = 1'b1;
            end else begin
                rem_w = sh[XLEN-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    if (!funct3[2]) begin
                        if (MUL_LAT == 1) begin
                            state_d  = StDone;
                            res_d    = mul_res;
                            rd_out_d = rd_adr_in;
                        end else begin
                            state_d = StMul;
                        end
                    end else if (div_zero || div_ovf) begin
                        state_d  = StDone;
                        res_d    = special_res;
                        rd_out_d = rd_adr_in;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                if (cnt_q == CntW'(MUL_LAT - 2)) begin
                    state_d  = StDone;
                    res_d    = mul_res;
                    rd_out_d = rd_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDiv: begin
                if (cnt_q == CntW'(DivCycles - 2)) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFix: begin
                state_d  = StDone;
                res_d    = fix_res;
                rd_out_d = rd_q;
            end
            StDone: begin
                if (!stall) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over completion: nothing is written.
        if (flush && !in_idle) begin
            state_d  = StIdle;
            res_d    = res_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            rd_out_q <= rd_out_d;
            if (accept) begin
                op_q <= funct3;
                a_q  <= rs1;
                b_q  <= rs2;
                rd_q <= rd_adr_in;
            end
            if (accept || state_q == StDiv) begin
                rem_q <= rem_w;
                quo_q <= quo_w;
            end
        end
    end

    assign busy       = (start & in_idle) | (state_q == StMul) | (state_q == StDiv)
                        | (state_q == StFix);
    assign done       = (state_q == StDone) & ~flush;
    assign result     = res_q;
    assign rd_adr_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a driver issues directed and random M-extension ops,
// a monitor pops expected results/latencies whenever done is seen.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        rst_pipe = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_adr_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_adr_out;

    ex_muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd_adr_in  (rd_adr_in),
        .kill       (kill),
        .rst_pipe   (rst_pipe),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_adr_out (rd_adr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          p;
        int              ia = $signed(a);
        int              ib = $signed(b);
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = longint'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop on the first done cycle, then demand stable outputs while done holds.
    exp_t cur;
    logic in_done = 1'b0;
    logic have_cur = 1'b0;
    initial forever begin
        @(negedge clk);
        if (done) begin
            if (!in_done) begin
                in_done = 1'b1;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got result 0x%0h, expected no done (cycle %0d)",
                             result, cyc);
                    have_cur = 1'b0;
                end else begin
                    cur = sbq.pop_front();
                    have_cur = 1'b1;
                    check("result", result, cur.res);
                    check("rd_adr_out", rd_adr_out, cur.rd);
                    check("latency", cyc - cur.t0, cur.lat);
                end
            end else if (have_cur) begin
                check("result_held", result, cur.res);
                check("rd_held", rd_adr_out, cur.rd);
            end
        end else begin
            in_done = 1'b0;
            have_cur = 1'b0;
        end
    end

    // Entered and left just after a posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int k);
        exp_t e;
        int   n;
        funct3 = f; rs1 = a; rs2 = b; rd_adr_in = rd; start = 1'b1; stall = (k > 0);
        e.res = model(f, a, b); e.rd = rd; e.t0 = cyc; e.lat = latency(f, a, b);
        sbq.push_back(e);
        @(negedge clk);
        check("busy_accept", busy, 1);
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        rd_adr_in = 5'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            check("busy_run", busy, 1);
            n++;
            if (n > 100) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
                void'(sbq.pop_front());
                stall = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        check("busy_in_done", busy, 0);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            start = 1'b1; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
            if (i == k - 1) stall = 1'b0;
            @(negedge clk);
            check("done_stalled", done, 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_drop", done, 0);
        check("busy_after", busy, 0);
        @(posedge clk); #1;
    endtask

    // Start an op and abort it j cycles after accept with kill or rst_pipe.
    task automatic abort_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int j, input logic use_pipe);
        funct3 = f; rs1 = a; rs2 = b; rd_adr_in = 5'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < j; i++) begin
            @(posedge clk); #1;
        end
        kill = ~use_pipe; rst_pipe = use_pipe;
        @(posedge clk); #1;
        kill = 1'b0; rst_pipe = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
    endtask

    logic [2:0]  rf;
    logic [31:0] ra, rb;

    initial begin
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rd", rd_adr_out, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 3);
        issue(3'd7, 32'd100, 32'd7, 5'd8, 0);
        issue(3'd5, 32'd5, 32'd0, 5'd9, 0);
        issue(3'd6, 32'd5, 32'd0, 5'd10, 2);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

        abort_op(3'd4, 32'd1000, 32'd3, 10, 1'b0);
        issue(3'd0, 32'd12, 32'd11, 5'd13, 0);
        abort_op(3'd0, 32'd3, 32'd4, 1, 1'b1);
        abort_op(3'd5, 32'hDEAD_BEEF, 32'd9, 32, 1'b0);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd14, 1);

        // start together with kill in IDLE is not accepted
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_accept_busy", busy, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 160; n++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 9) == 0) begin
                if (rf[2]) abort_op(rf, ra, 32'($urandom_range(1, 1000)),
                                    $urandom_range(1, 32), 1'($urandom));
                else abort_op(rf, ra, rb, 1, 1'($urandom));
            end else begin
                issue(rf, ra, rb, 5'($urandom), ($urandom_range(0, 3) == 0) ?
                      $urandom_range(1, 3) : 0);
            end
        end

        // asynchronous reset in the middle of a divide
        funct3 = 3'd4; rs1 = $urandom; rs2 = 32'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_rd", rd_adr_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("arst_after_result", result, 0);
        @(posedge clk); #1;
        issue(3'd7, 32'd1234, 32'd10, 5'd31, 0);

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
